// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl
// Round sequencer for the SHA-256 compression core. It drives a 7-bit
// loadable round counter (load, load data, enable) and reads its value back
// to issue round indices. A job runs 1..3 compression blocks. One result is
// then handed to the downstream compare logic with a done/ack handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, nblocks      job request (sampled in IDLE) and block count 1..3
//   abort               synchronous abort back to IDLE
//   ctr_value           round counter read-back
//   ctr_ld, ctr_ld_data counter load strobe and value (always 0)
//   ctr_en              counter increment enable
//   round_valid         round_idx is valid this cycle
//   round_idx           current round index (ctr_value[5:0])
//   block_idx           current block, 0-based
//   blk_init, blk_final per-block chaining-value load / accumulate pulses
//   busy                high in every state except IDLE
//   done, ack           result valid (held) / downstream accept
//   err                 sticky protocol error, cleared on next accepted start
module sha_round_ctrl #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] nblocks,
    input  logic       abort,
    input  logic [6:0] ctr_value,
    output logic       ctr_ld,
    output logic [6:0] ctr_ld_data,
    output logic       ctr_en,
    output logic       round_valid,
    output logic [5:0] round_idx,
    output logic [1:0] block_idx,
    output logic       blk_init,
    output logic       blk_final,
    output logic       busy,
    output logic       done,
    input  logic       ack,
    output logic       err
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
    localparam logic [6:0] NUM_ROUNDS = 7'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] block_idx_q, block_idx_d;
    logic [1:0] nblocks_q, nblocks_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            block_idx_q <= '0;
            nblocks_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_idx_q <= block_idx_d;
            nblocks_q   <= nblocks_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        block_idx_d = block_idx_q;
        nblocks_d   = nblocks_q;
        err_d       = err_q;
        ctr_ld      = 1'b0;
        ctr_en      = 1'b0;
        round_valid = 1'b0;
        round_idx   = '0;
        blk_init    = 1'b0;
        blk_final   = 1'b0;
        done        = 1'b0;

        if (abort) begin
            // Abort wins over everything: strobes and done stay low this cycle.
            state_d     = S_IDLE;
            block_idx_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && (nblocks != 2'd0)) begin
                        state_d     = S_LOAD;
                        block_idx_d = '0;
                        nblocks_d   = nblocks;
                        err_d       = 1'b0;
                    end
                end
                S_LOAD: begin
                    ctr_ld   = 1'b1;
                    blk_init = 1'b1;
                    state_d  = S_ROUND;
                end
                S_ROUND: begin
                    if (ctr_value >= NUM_ROUNDS) begin
                        // Counter out of range: abandon the block without blk_final.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        round_valid = 1'b1;
                        round_idx   = ctr_value[5:0];
                        if (ctr_value == LAST_ROUND) begin
                            state_d = S_FINAL;
                        end else begin
                            ctr_en = 1'b1;
                        end
                    end
                end
                S_FINAL: begin
                    blk_final = 1'b1;
                    if (block_idx_q == nblocks_q - 2'd1) begin
                        state_d = S_DONE;
                    end else begin
                        block_idx_d = block_idx_q + 2'd1;
                        state_d     = S_LOAD;
                    end
                end
                S_DONE: begin
                    done = 1'b1;
                    if (ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign ctr_ld_data = '0;
    assign block_idx   = block_idx_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_sha_round_ctrl.sv
module tb_sha_round_ctrl;

    localparam int R = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] nblocks = 2'd0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;
    logic [6:0] ctr_value;
    logic [6:0] ctr_q;
    logic [6:0] force_val = 7'd0;
    logic       force_en = 1'b0;

    logic       ctr_ld, ctr_en, round_valid, blk_init, blk_final, busy, done, err;
    logic [6:0] ctr_ld_data;
    logic [5:0] round_idx;
    logic [1:0] block_idx;

    sha_round_ctrl #(.ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nblocks(nblocks), .abort(abort),
        .ctr_value(ctr_value), .ctr_ld(ctr_ld), .ctr_ld_data(ctr_ld_data),
        .ctr_en(ctr_en), .round_valid(round_valid), .round_idx(round_idx),
        .block_idx(block_idx), .blk_init(blk_init), .blk_final(blk_final),
        .busy(busy), .done(done), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    // External round counter: one-cycle register latency, optional override.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctr_q <= 7'd0;
        else if (ctr_ld) ctr_q <= ctr_ld_data;
        else if (ctr_en) ctr_q <= ctr_q + 7'd1;
    end
    assign ctr_value = force_en ? force_val : ctr_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Job-level model: a job is a count of cycles since acceptance; each block
    // is LOAD, R rounds, FINAL. Phases follow from division of that count.
    bit m_active = 0, m_done = 0, m_err = 0;
    int m_k = 0, m_n = 0, m_blk = 0;

    always @(posedge clk) begin
        int b, p;
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_err = 0; m_k = 0; m_n = 0; m_blk = 0;
        end else if (abort) begin
            m_active = 0; m_done = 0; m_blk = 0;
        end else if (m_active) begin
            b = (m_k - 1) / (R + 2);
            p = (m_k - 1) % (R + 2);
            if (p >= 1 && p <= R && int'(ctr_value) >= R) begin
                m_err = 1; m_active = 0; m_done = 1; m_blk = b;
            end else begin
                m_k++;
                if (m_k == 1 + m_n * (R + 2)) begin
                    m_active = 0; m_done = 1; m_blk = m_n - 1;
                end
            end
        end else if (m_done) begin
            if (ack) m_done = 0;
        end else if (start && nblocks != 2'd0) begin
            m_active = 1; m_k = 1; m_n = int'(nblocks); m_err = 0; m_blk = 0;
        end
    end

    int c0 = -100000;
    logic       lg_ld[256], lg_init[256], lg_final[256], lg_done[256];
    logic       lg_en[256], lg_rv[256], lg_busy[256], lg_err[256];
    logic [5:0] lg_idx[256];
    logic [1:0] lg_blk[256];

    task automatic clear_logs();
        for (int i = 0; i < 256; i++) begin
            lg_ld[i] = 0; lg_init[i] = 0; lg_final[i] = 0; lg_done[i] = 0;
            lg_en[i] = 0; lg_rv[i] = 0; lg_busy[i] = 0; lg_err[i] = 0;
            lg_idx[i] = 0; lg_blk[i] = 0;
        end
    endtask

    // Compare every cycle against the model, and log per relative cycle.
    always @(negedge clk) begin
        int b, p, rel;
        bit e_ld, e_init, e_final, e_en, e_rv, e_done, e_busy, e_err, rnd, bad;
        int e_idx, e_blk;
        e_ld = 0; e_init = 0; e_final = 0; e_en = 0; e_rv = 0; e_done = 0;
        e_busy = 0; e_err = 0; e_idx = 0; e_blk = 0;
        if (rst_n) begin
            b = m_active ? (m_k - 1) / (R + 2) : 0;
            p = m_active ? (m_k - 1) % (R + 2) : -1;
            rnd = m_active && p >= 1 && p <= R;
            bad = int'(ctr_value) >= R;
            e_busy  = m_active || m_done;
            e_ld    = m_active && p == 0 && !abort;
            e_init  = e_ld;
            e_final = m_active && p == R + 1 && !abort;
            e_rv    = rnd && !bad && !abort;
            e_idx   = e_rv ? p - 1 : 0;
            e_en    = e_rv && (p - 1 != R - 1);
            e_done  = m_done && !abort;
            e_blk   = m_active ? b : m_blk;
            e_err   = m_err;
        end
        chk("ctr_ld", 32'(ctr_ld), 32'(e_ld));
        chk("ctr_ld_data", 32'(ctr_ld_data), 32'd0);
        chk("blk_init", 32'(blk_init), 32'(e_init));
        chk("blk_final", 32'(blk_final), 32'(e_final));
        chk("ctr_en", 32'(ctr_en), 32'(e_en));
        chk("round_valid", 32'(round_valid), 32'(e_rv));
        chk("round_idx", 32'(round_idx), 32'(e_idx));
        chk("block_idx", 32'(block_idx), 32'(e_blk));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        rel = cyc - c0;
        if (rel >= 0 && rel < 256) begin
            lg_ld[rel] = ctr_ld; lg_init[rel] = blk_init; lg_final[rel] = blk_final;
            lg_done[rel] = done; lg_en[rel] = ctr_en; lg_rv[rel] = round_valid;
            lg_busy[rel] = busy; lg_err[rel] = err; lg_idx[rel] = round_idx;
            lg_blk[rel] = block_idx;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int r);
        int guard;
        guard = 0;
        while (cyc - c0 < r && guard < 1000) begin
            next_cycle();
            guard++;
        end
    endtask

    task automatic begin_job(input logic [1:0] nb);
        clear_logs();
        start = 1'b1;
        nblocks = nb;
        c0 = cyc;
        next_cycle();
        start = 1'b0;
        nblocks = 2'd0;
    endtask

    initial begin
        repeat (3) next_cycle();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // Single block, ack at 70.
        begin_job(2'd1);
        goto_rel(70);
        ack = 1'b1;
        next_cycle();
        ack = 1'b0;
        goto_rel(73);
        chk("j1 ld@1", 32'(lg_ld[1]), 32'd1);
        chk("j1 idx@2", 32'(lg_idx[2]), 32'd0);
        chk("j1 idx@65", 32'(lg_idx[65]), 32'd63);
        chk("j1 en@64", 32'(lg_en[64]), 32'd1);
        chk("j1 en@65", 32'(lg_en[65]), 32'd0);
        chk("j1 final@66", 32'(lg_final[66]), 32'd1);
        chk("j1 done@66", 32'(lg_done[66]), 32'd0);
        chk("j1 done@67", 32'(lg_done[67]), 32'd1);
        chk("j1 busy@70", 32'(lg_busy[70]), 32'd1);
        chk("j1 busy@71", 32'(lg_busy[71]), 32'd0);

        // Three blocks, with an ignored start while busy.
        begin_job(2'd3);
        goto_rel(10);
        start = 1'b1;
        nblocks = 2'd2;
        next_cycle();
        start = 1'b0;
        nblocks = 2'd0;
        goto_rel(200);
        ack = 1'b1;
        next_cycle();
        ack = 1'b0;
        goto_rel(202);
        chk("j2 init@1", 32'(lg_init[1]), 32'd1);
        chk("j2 init@67", 32'(lg_init[67]), 32'd1);
        chk("j2 init@133", 32'(lg_init[133]), 32'd1);
        chk("j2 final@66", 32'(lg_final[66]), 32'd1);
        chk("j2 final@132", 32'(lg_final[132]), 32'd1);
        chk("j2 final@198", 32'(lg_final[198]), 32'd1);
        chk("j2 done@198", 32'(lg_done[198]), 32'd0);
        chk("j2 done@199", 32'(lg_done[199]), 32'd1);
        chk("j2 blk@5", 32'(lg_blk[5]), 32'd0);
        chk("j2 blk@70", 32'(lg_blk[70]), 32'd1);
        chk("j2 blk@140", 32'(lg_blk[140]), 32'd2);

        // Counter forced out of range, then done held 5 cycles.
        begin_job(2'd1);
        goto_rel(20);
        force_en = 1'b1;
        force_val = 7'd100;
        next_cycle();
        force_en = 1'b0;
        goto_rel(26);
        ack = 1'b1;
        next_cycle();
        ack = 1'b0;
        goto_rel(28);
        chk("j3 rv@20", 32'(lg_rv[20]), 32'd0);
        chk("j3 en@20", 32'(lg_en[20]), 32'd0);
        chk("j3 final@21", 32'(lg_final[21]), 32'd0);
        chk("j3 done@21", 32'(lg_done[21]), 32'd1);
        chk("j3 err@21", 32'(lg_err[21]), 32'd1);
        chk("j3 done@25", 32'(lg_done[25]), 32'd1);
        chk("j3 ld@23", 32'(lg_ld[23]), 32'd0);
        chk("j3 busy@27", 32'(lg_busy[27]), 32'd0);

        // Start with zero blocks is ignored and keeps err.
        clear_logs();
        c0 = cyc;
        start = 1'b1;
        nblocks = 2'd0;
        goto_rel(3);
        start = 1'b0;
        goto_rel(5);
        chk("j4 busy@1", 32'(lg_busy[1]), 32'd0);
        chk("j4 busy@4", 32'(lg_busy[4]), 32'd0);
        chk("j4 ld@1", 32'(lg_ld[1]), 32'd0);
        chk("j4 err@2", 32'(lg_err[2]), 32'd1);

        // Two blocks, abort at round 30 of block 1.
        begin_job(2'd2);
        goto_rel(98);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        goto_rel(105);
        chk("j5 err@1", 32'(lg_err[1]), 32'd0);
        chk("j5 idx@97", 32'(lg_idx[97]), 32'd29);
        chk("j5 rv@97", 32'(lg_rv[97]), 32'd1);
        chk("j5 blk@98", 32'(lg_blk[98]), 32'd1);
        chk("j5 rv@98", 32'(lg_rv[98]), 32'd0);
        chk("j5 en@98", 32'(lg_en[98]), 32'd0);
        chk("j5 busy@99", 32'(lg_busy[99]), 32'd0);
        chk("j5 blk@99", 32'(lg_blk[99]), 32'd0);
        chk("j5 done@101", 32'(lg_done[101]), 32'd0);

        // Reset asserted at round 10.
        begin_job(2'd1);
        goto_rel(12);
        rst_n = 1'b0;
        #1;
        chk("j6 idx@11", 32'(lg_idx[11]), 32'd9);
        chk("j6 async busy", 32'(busy), 32'd0);
        chk("j6 async rv", 32'(round_valid), 32'd0);
        chk("j6 async en", 32'(ctr_en), 32'd0);
        chk("j6 async idx", 32'(round_idx), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        repeat (4) next_cycle();
        chk("j6 busy after", 32'(busy), 32'd0);
        chk("j6 done after", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
